// File: rtl/armleocpu_axi4lite_regif_pkg.sv
// Shared definitions for the AXI4-Lite register interface.
// Response codes and FSM state encodings.
package armleocpu_defines;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_W_ACCESS = 3'd1;
  localparam logic [2:0] ST_W_RESP   = 3'd2;
  localparam logic [2:0] ST_R_ACCESS = 3'd3;
  localparam logic [2:0] ST_R_RESP   = 3'd4;

endpackage

// File: rtl/armleocpu_axi4lite_regif_if.sv
// AXI4-Lite bus bundle between a master and the register interface.
// The master drives requests, the slave drives readies and responses.
interface armleocpu_axi4lite_regif_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AXI_AWADDR;
  logic                  AXI_AWVALID;
  logic                  AXI_AWREADY;
  logic [31:0]           AXI_WDATA;
  logic [3:0]            AXI_WSTRB;
  logic                  AXI_WVALID;
  logic                  AXI_WREADY;
  logic [1:0]            AXI_BRESP;
  logic                  AXI_BVALID;
  logic                  AXI_BREADY;
  logic [ADDR_WIDTH-1:0] AXI_ARADDR;
  logic                  AXI_ARVALID;
  logic                  AXI_ARREADY;
  logic [31:0]           AXI_RDATA;
  logic [1:0]            AXI_RRESP;
  logic                  AXI_RVALID;
  logic                  AXI_RREADY;

  modport master (
    output AXI_AWADDR, AXI_AWVALID,
    input  AXI_AWREADY,
    output AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    input  AXI_WREADY,
    input  AXI_BRESP, AXI_BVALID,
    output AXI_BREADY,
    output AXI_ARADDR, AXI_ARVALID,
    input  AXI_ARREADY,
    input  AXI_RDATA, AXI_RRESP, AXI_RVALID,
    output AXI_RREADY
  );

  modport slave (
    input  AXI_AWADDR, AXI_AWVALID,
    output AXI_AWREADY,
    input  AXI_WDATA, AXI_WSTRB, AXI_WVALID,
    output AXI_WREADY,
    output AXI_BRESP, AXI_BVALID,
    input  AXI_BREADY,
    input  AXI_ARADDR, AXI_ARVALID,
    output AXI_ARREADY,
    output AXI_RDATA, AXI_RRESP, AXI_RVALID,
    input  AXI_RREADY
  );
endinterface

// File: rtl/armleocpu_axi4lite_regif_regslot.sv
// One-entry holding register for a single AXI channel.
// Ready is purely the inverse of the full flag.
module armleocpu_regslot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  logic             r_full;
  logic [WIDTH-1:0] r_data;

  assign in_ready = !r_full;
  assign full     = r_full;
  assign data     = r_data;

  // Load on handshake, release when the consumer clears the slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (clear) begin
      r_full <= 1'b0;
    end else if (in_valid && !r_full) begin
      r_full <= 1'b1;
      r_data <= in_data;
    end
  end
endmodule

// File: rtl/armleocpu_axi4lite_regif.sv
// AXI4-Lite slave front end driving a simple strobe register bus.
// Buffers AW/W/AR, arbitrates round-robin, one access in flight.
module armleocpu_axi4lite_regif
  import armleocpu_defines::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  armleocpu_axi4lite_regif_if.slave axi,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic                  read,
  output logic [31:0]           write_data,
  output logic [3:0]            write_byteenable,
  input  logic [31:0]           read_data,
  input  logic                  address_error,
  input  logic                  write_error
);
  logic [2:0]            r_state;
  logic                  r_rr;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wbe;
  logic [1:0]            r_bresp;
  logic [1:0]            r_rresp;
  logic [31:0]           r_rdata;

  logic                  w_aw_full;
  logic                  w_w_full;
  logic                  w_ar_full;
  logic [ADDR_WIDTH-1:0] w_aw_data;
  logic [35:0]           w_w_data;
  logic [ADDR_WIDTH-1:0] w_ar_data;
  logic                  w_misaligned;
  logic                  w_wr_err;
  logic                  w_rd_err;
  logic                  w_wpend;
  logic                  w_rpend;
  logic                  w_pick_rd;
  logic                  w_pick_wr;

  armleocpu_regslot #(.WIDTH(ADDR_WIDTH)) u_aw (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (axi.AXI_AWVALID),
    .in_ready (axi.AXI_AWREADY),
    .in_data  (axi.AXI_AWADDR),
    .clear    (r_state == ST_W_ACCESS),
    .full     (w_aw_full),
    .data     (w_aw_data)
  );

  armleocpu_regslot #(.WIDTH(36)) u_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (axi.AXI_WVALID),
    .in_ready (axi.AXI_WREADY),
    .in_data  ({axi.AXI_WSTRB, axi.AXI_WDATA}),
    .clear    (r_state == ST_W_ACCESS),
    .full     (w_w_full),
    .data     (w_w_data)
  );

  armleocpu_regslot #(.WIDTH(ADDR_WIDTH)) u_ar (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (axi.AXI_ARVALID),
    .in_ready (axi.AXI_ARREADY),
    .in_data  (axi.AXI_ARADDR),
    .clear    (r_state == ST_R_ACCESS),
    .full     (w_ar_full),
    .data     (w_ar_data)
  );

  assign w_misaligned = (ALIGN_CHECK != 0) &&
                        (r_address[1:0] != 2'b00);
  assign w_wr_err = address_error | write_error | w_misaligned;
  assign w_rd_err = address_error | w_misaligned;

  assign w_wpend   = w_aw_full & w_w_full;
  assign w_rpend   = w_ar_full;
  assign w_pick_rd = w_rpend & (!w_wpend | !r_rr);
  assign w_pick_wr = w_wpend & (!w_rpend | r_rr);

  assign address          = r_address;
  assign write_data       = r_wdata;
  assign write_byteenable = r_wbe;
  assign write = (r_state == ST_W_ACCESS) && !w_wr_err;
  assign read  = (r_state == ST_R_ACCESS) && !w_rd_err;

  assign axi.AXI_BVALID = (r_state == ST_W_RESP);
  assign axi.AXI_BRESP  = r_bresp;
  assign axi.AXI_RVALID = (r_state == ST_R_RESP);
  assign axi.AXI_RRESP  = r_rresp;
  assign axi.AXI_RDATA  = r_rdata;

  // Arbitration, access sequencing and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr      <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
      r_wbe     <= '0;
      r_bresp   <= AXI_RESP_OKAY;
      r_rresp   <= AXI_RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pick_rd) begin
            r_state   <= ST_R_ACCESS;
            r_address <= w_ar_data;
            r_rr      <= 1'b1;
          end else if (w_pick_wr) begin
            r_state   <= ST_W_ACCESS;
            r_address <= w_aw_data;
            r_wdata   <= w_w_data[31:0];
            r_wbe     <= w_w_data[35:32];
            r_rr      <= 1'b0;
          end
        end
        ST_W_ACCESS: begin
          r_bresp <= w_wr_err ? AXI_RESP_SLVERR
                              : AXI_RESP_OKAY;
          r_state <= ST_W_RESP;
        end
        ST_W_RESP: begin
          if (axi.AXI_BREADY)
            r_state <= ST_IDLE;
        end
        ST_R_ACCESS: begin
          r_rdata <= w_rd_err ? 32'h0 : read_data;
          r_rresp <= w_rd_err ? AXI_RESP_SLVERR
                              : AXI_RESP_OKAY;
          r_state <= ST_R_RESP;
        end
        ST_R_RESP: begin
          if (axi.AXI_RREADY)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_armleocpu_axi4lite_regif.sv
// Testbench for the AXI4-Lite register interface.
// Vector table, directed corner cases and randomized model checks.
module tb_armleocpu_axi4lite_regif;
  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] write_data;
  logic [3:0]  write_byteenable;
  logic [31:0] read_data;
  logic        address_error;
  logic        write_error;

  armleocpu_axi4lite_regif_if #(.ADDR_WIDTH(32)) axi ();

  armleocpu_axi4lite_regif #(
    .ADDR_WIDTH  (32),
    .ALIGN_CHECK (1)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .axi              (axi.slave),
    .address          (address),
    .write            (write),
    .read             (read),
    .write_data       (write_data),
    .write_byteenable (write_byteenable),
    .read_data        (read_data),
    .address_error    (address_error),
    .write_error      (write_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Peripheral map: 0x0..0xF and 0x4000..0x403F are RW words,
  // 0xBFF8 is read-only returning CAFEBABE, all else unmapped.
  function automatic bit f_rw(logic [31:0] a);
    return (a < 32'h10) || (a >= 32'h4000 && a < 32'h4040);
  endfunction

  function automatic bit f_ro(logic [31:0] a);
    return {a[31:2], 2'b00} == 32'hBFF8;
  endfunction

  function automatic int f_idx(logic [31:0] a);
    return (a < 32'h10) ? int'(a[3:2]) : 4 + int'(a[5:2]);
  endfunction

  logic [31:0] pmem [20];
  logic [31:0] rmem [20];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_addr;

  always_comb begin
    address_error = !(f_rw(address) || f_ro(address));
    write_error   = f_ro(address);
    read_data     = 32'hDEADBEEF;
    if (f_ro(address))
      read_data = 32'hCAFEBABE;
    else if (f_rw(address))
      read_data = pmem[f_idx(address)];
  end

  always @(posedge clk) begin
    if (write) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= address;
      if (f_rw(address))
        for (int b = 0; b < 4; b++)
          if (write_byteenable[b])
            pmem[f_idx(address)][8*b +: 8] <= write_data[8*b +: 8];
    end
    if (read)
      rd_cnt <= rd_cnt + 1;
  end

  task automatic check(string name, logic [127:0] act,
                       logic [127:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ref_write(input logic [31:0] a, d,
                           input logic [3:0] s,
                           output logic [1:0] resp,
                           output bit strobe);
    bit err;
    err = (a[1:0] != 2'b00) || !(f_rw(a) || f_ro(a)) || f_ro(a);
    strobe = !err;
    resp = err ? 2'b10 : 2'b00;
    if (!err)
      for (int b = 0; b < 4; b++)
        if (s[b]) rmem[f_idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic ref_read(input logic [31:0] a,
                          output logic [1:0] resp,
                          output logic [31:0] data,
                          output bit strobe);
    bit err;
    err = (a[1:0] != 2'b00) || !(f_rw(a) || f_ro(a));
    strobe = !err;
    resp = err ? 2'b10 : 2'b00;
    data = 32'h0;
    if (!err) data = f_ro(a) ? 32'hCAFEBABE : rmem[f_idx(a)];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    axi.AXI_AWVALID = 1'b0;
    axi.AXI_WVALID  = 1'b0;
    axi.AXI_ARVALID = 1'b0;
    axi.AXI_BREADY  = 1'b0;
    axi.AXI_RREADY  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_bus();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic axi_write(input logic [31:0] a, d,
                           input logic [3:0] s,
                           input int bdelay,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    axi.AXI_AWADDR  = a;
    axi.AXI_AWVALID = 1'b1;
    axi.AXI_WDATA   = d;
    axi.AXI_WSTRB   = s;
    axi.AXI_WVALID  = 1'b1;
    aw_done = 0;
    w_done  = 0;
    n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      aw_hs = axi.AXI_AWVALID && axi.AXI_AWREADY;
      w_hs  = axi.AXI_WVALID && axi.AXI_WREADY;
      step();
      if (aw_hs) begin aw_done = 1; axi.AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  axi.AXI_WVALID = 1'b0; end
      n++;
    end
    axi.AXI_AWVALID = 1'b0;
    axi.AXI_WVALID  = 1'b0;
    n = 0;
    while (!axi.AXI_BVALID && n < 40) begin step(); n++; end
    check("bvalid_wait", axi.AXI_BVALID, 1'b1);
    repeat (bdelay) step();
    resp = axi.AXI_BRESP;
    axi.AXI_BREADY = 1'b1;
    step();
    axi.AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a,
                          input int rdelay,
                          output logic [1:0] resp,
                          output logic [31:0] data);
    int n;
    axi.AXI_ARADDR  = a;
    axi.AXI_ARVALID = 1'b1;
    n = 0;
    while (!axi.AXI_ARREADY && n < 40) begin step(); n++; end
    step();
    axi.AXI_ARVALID = 1'b0;
    n = 0;
    while (!axi.AXI_RVALID && n < 40) begin step(); n++; end
    check("rvalid_wait", axi.AXI_RVALID, 1'b1);
    repeat (rdelay) step();
    resp = axi.AXI_RRESP;
    data = axi.AXI_RDATA;
    axi.AXI_RREADY = 1'b1;
    step();
    axi.AXI_RREADY = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          strobe;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, eresp;
    logic [31:0] rdata, edata, a;
    bit          estb;
    int          c0, c1, k;

    vecs[0] = '{1, 32'h4000, 32'h12345678, 4'hF, 2'b00, 32'h0, 1};
    vecs[1] = '{0, 32'h4000, 32'h0, 4'h0, 2'b00, 32'h12345678, 1};
    vecs[2] = '{0, 32'hBFF8, 32'h0, 4'h0, 2'b00, 32'hCAFEBABE, 1};
    vecs[3] = '{1, 32'hBFF8, 32'h11111111, 4'hF, 2'b10, 32'h0, 0};
    vecs[4] = '{0, 32'h7000, 32'h0, 4'h0, 2'b10, 32'h0, 0};
    vecs[5] = '{0, 32'h0002, 32'h0, 4'h0, 2'b10, 32'h0, 0};
    vecs[6] = '{1, 32'h4006, 32'h22222222, 4'hF, 2'b10, 32'h0, 0};
    vecs[7] = '{1, 32'h4004, 32'hAABBCCDD, 4'h3, 2'b00, 32'h0, 1};
    vecs[8] = '{0, 32'h4004, 32'h0, 4'h0, 2'b00, 32'h0000CCDD, 1};
    vecs[9] = '{1, 32'h7000, 32'h33333333, 4'hF, 2'b10, 32'h0, 0};

    for (int i = 0; i < 20; i++) begin
      pmem[i] = 32'h0;
      rmem[i] = 32'h0;
    end
    axi.AXI_AWADDR = '0;
    axi.AXI_WDATA  = '0;
    axi.AXI_WSTRB  = '0;
    axi.AXI_ARADDR = '0;
    idle_bus();
    rst_n = 1'b0;
    step();
    check("rst_ready",
          {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY}, 3'b111);
    check("rst_valid",
          {axi.AXI_BVALID, axi.AXI_RVALID, write, read}, 4'b0);
    check("rst_resp",
          {axi.AXI_BRESP, axi.AXI_RRESP, axi.AXI_RDATA}, 36'h0);
    check("rst_bus", {address, write_data, write_byteenable}, 68'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      c0 = wr_cnt;
      c1 = rd_cnt;
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, i % 3, resp);
        ref_write(vecs[i].addr, vecs[i].data, vecs[i].strb, eresp, estb);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_wstrobe", i), wr_cnt - c0,
              vecs[i].strobe ? 1 : 0);
        if (vecs[i].strobe)
          check($sformatf("vec%0d_waddr", i), last_addr, vecs[i].addr);
      end else begin
        axi_read(vecs[i].addr, i % 3, resp, rdata);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
        check($sformatf("vec%0d_rstrobe", i), rd_cnt - c1,
              vecs[i].strobe ? 1 : 0);
      end
    end

    // Write latency: handshake, strobe, then response
    c0 = wr_cnt;
    axi.AXI_AWADDR  = 32'h4000;
    axi.AXI_WDATA   = 32'h12345678;
    axi.AXI_WSTRB   = 4'hF;
    axi.AXI_AWVALID = 1'b1;
    axi.AXI_WVALID  = 1'b1;
    check("lat_w_ready", {axi.AXI_AWREADY, axi.AXI_WREADY}, 2'b11);
    step();
    axi.AXI_AWVALID = 1'b0;
    axi.AXI_WVALID  = 1'b0;
    check("lat_w_n0", write, 1'b0);
    step();
    check("lat_w_strobe", {write, address, write_data, write_byteenable,
          axi.AXI_BVALID}, {1'b1, 32'h4000, 32'h12345678, 4'hF, 1'b0});
    step();
    check("lat_w_resp", {write, axi.AXI_BVALID, axi.AXI_BRESP},
          {1'b0, 1'b1, 2'b00});
    axi.AXI_BREADY = 1'b1;
    step();
    axi.AXI_BREADY = 1'b0;
    check("lat_w_once", wr_cnt - c0, 1);
    ref_write(32'h4000, 32'h12345678, 4'hF, eresp, estb);

    // Read latency
    axi.AXI_ARADDR  = 32'hBFF8;
    axi.AXI_ARVALID = 1'b1;
    step();
    axi.AXI_ARVALID = 1'b0;
    check("lat_r_n0", read, 1'b0);
    step();
    check("lat_r_strobe", {read, address, axi.AXI_RVALID},
          {1'b1, 32'hBFF8, 1'b0});
    step();
    check("lat_r_resp", {read, axi.AXI_RVALID, axi.AXI_RRESP,
          axi.AXI_RDATA}, {1'b0, 1'b1, 2'b00, 32'hCAFEBABE});
    axi.AXI_RREADY = 1'b1;
    step();
    axi.AXI_RREADY = 1'b0;

    // W arrives three cycles before AW
    c0 = wr_cnt;
    axi.AXI_WDATA  = 32'h1;
    axi.AXI_WSTRB  = 4'b0101;
    axi.AXI_WVALID = 1'b1;
    step();
    axi.AXI_WVALID = 1'b0;
    k = 0;
    repeat (3) begin
      step();
      if (write) k++;
    end
    check("order_no_strobe", {k, wr_cnt - c0}, 64'h0);
    check("order_wready_low", axi.AXI_WREADY, 1'b0);
    axi.AXI_AWADDR  = 32'h0;
    axi.AXI_AWVALID = 1'b1;
    step();
    axi.AXI_AWVALID = 1'b0;
    step();
    check("order_strobe", {write, address, write_data, write_byteenable},
          {1'b1, 32'h0, 32'h1, 4'b0101});
    step();
    axi.AXI_BREADY = 1'b1;
    step();
    axi.AXI_BREADY = 1'b0;
    ref_write(32'h0, 32'h1, 4'b0101, eresp, estb);

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 4);
      unique case (k)
        0: a = 32'h4000 + 4 * $urandom_range(0, 15);
        1: a = 4 * $urandom_range(0, 3);
        2: a = 32'hBFF8;
        3: a = 32'h7000 + 4 * $urandom_range(0, 15);
        default: a = 32'h4000 + 4 * $urandom_range(0, 15)
                     + $urandom_range(1, 3);
      endcase
      c0 = wr_cnt;
      c1 = rd_cnt;
      if ($urandom_range(0, 1) == 1) begin
        rdata = $urandom;
        k = $urandom_range(0, 15);
        axi_write(a, rdata, k[3:0], $urandom_range(0, 2), resp);
        ref_write(a, rdata, k[3:0], eresp, estb);
        check("rnd_bresp", resp, eresp);
        check("rnd_wstrobe", wr_cnt - c0, estb ? 1 : 0);
      end else begin
        axi_read(a, $urandom_range(0, 2), resp, rdata);
        ref_read(a, eresp, edata, estb);
        check("rnd_rresp", resp, eresp);
        check("rnd_rdata", rdata, edata);
        check("rnd_rstrobe", rd_cnt - c1, estb ? 1 : 0);
      end
    end

    // Contention after reset: read wins, then write, with stalls
    do_reset();
    c0 = wr_cnt;
    axi.AXI_ARADDR  = 32'hBFF8;
    axi.AXI_AWADDR  = 32'h4004;
    axi.AXI_WDATA   = 32'h55AA55AA;
    axi.AXI_WSTRB   = 4'hF;
    axi.AXI_ARVALID = 1'b1;
    axi.AXI_AWVALID = 1'b1;
    axi.AXI_WVALID  = 1'b1;
    step();
    idle_bus();
    k = 0;
    while (!axi.AXI_RVALID && k < 40) begin step(); k++; end
    check("cont_rvalid", axi.AXI_RVALID, 1'b1);
    check("cont_no_write", {axi.AXI_BVALID, wr_cnt - c0}, 33'h0);
    k = 0;
    repeat (5) begin
      step();
      if (!(axi.AXI_RVALID && axi.AXI_RDATA == 32'hCAFEBABE &&
            axi.AXI_RRESP == 2'b00 && !axi.AXI_BVALID)) k++;
    end
    check("cont_r_stable", k, 0);
    axi.AXI_RREADY = 1'b1;
    step();
    axi.AXI_RREADY = 1'b0;
    k = 0;
    while (!axi.AXI_BVALID && k < 40) begin step(); k++; end
    check("cont_bvalid", axi.AXI_BVALID, 1'b1);
    k = 0;
    repeat (5) begin
      step();
      if (!(axi.AXI_BVALID && axi.AXI_BRESP == 2'b00 &&
            !axi.AXI_RVALID)) k++;
    end
    check("cont_b_stable", k, 0);
    axi.AXI_BREADY = 1'b1;
    step();
    axi.AXI_BREADY = 1'b0;
    check("cont_write", {wr_cnt - c0, last_addr}, {32'd1, 32'h4004});
    ref_write(32'h4004, 32'h55AA55AA, 4'hF, eresp, estb);

    // Reset during W_RESP with a read waiting in its slot
    axi.AXI_AWADDR  = 32'h4010;
    axi.AXI_WDATA   = 32'h0F0F0F0F;
    axi.AXI_AWVALID = 1'b1;
    axi.AXI_WVALID  = 1'b1;
    step();
    idle_bus();
    k = 0;
    while (!axi.AXI_BVALID && k < 40) begin step(); k++; end
    check("rstmid_bvalid", axi.AXI_BVALID, 1'b1);
    ref_write(32'h4010, 32'h0F0F0F0F, 4'hF, eresp, estb);
    axi.AXI_ARADDR  = 32'h4000;
    axi.AXI_ARVALID = 1'b1;
    step();
    axi.AXI_ARVALID = 1'b0;
    c0 = wr_cnt;
    c1 = rd_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_drop", {axi.AXI_BVALID, axi.AXI_RVALID}, 2'b00);
    check("rstmid_ready",
          {axi.AXI_AWREADY, axi.AXI_WREADY, axi.AXI_ARREADY}, 3'b111);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("rstmid_quiet", {wr_cnt - c0, rd_cnt - c1,
          axi.AXI_BVALID, axi.AXI_RVALID}, 66'h0);

    // Memory survives: a follow-up read sees the model's value
    axi_read(32'h4010, 0, resp, rdata);
    ref_read(32'h4010, eresp, edata, estb);
    check("post_rst_read", {resp, rdata}, {eresp, edata});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/armleocpu_axi4lite_regif.md
Name: armleocpu_axi4lite_regif

Overview:
AXI4-Lite slave front end that sits directly upstream of register-file peripherals such as the CLINT. It terminates the AXI4-Lite handshakes and buffers the AW, W and AR channels. It issues one-cycle `write`/`read` strobes on a simple register bus and returns `BRESP`/`RRESP` from the peripheral's combinational error flags. It serialises reads and writes with round-robin arbitration and blocks misaligned or erroneous writes.

Parameters:
ADDR_WIDTH, 32, width of AXI and register-bus address.
ALIGN_CHECK, 1, when 1 any access with addr[1:0]!=0 returns SLVERR and no strobe reaches the peripheral.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
AXI_AWADDR  in  ADDR_WIDTH  write address
AXI_AWVALID  in  1  write address valid
AXI_AWREADY  out  1  write address ready
AXI_WDATA  in  32  write data
AXI_WSTRB  in  4  write byte strobes
AXI_WVALID  in  1  write data valid
AXI_WREADY  out  1  write data ready
AXI_BRESP  out  2  write response
AXI_BVALID  out  1  write response valid
AXI_BREADY  in  1  write response ready
AXI_ARADDR  in  ADDR_WIDTH  read address
AXI_ARVALID  in  1  read address valid
AXI_ARREADY  out  1  read address ready
AXI_RDATA  out  32  read data
AXI_RRESP  out  2  read response
AXI_RVALID  out  1  read data valid
AXI_RREADY  in  1  read data ready
address  out  ADDR_WIDTH  register-bus address
write  out  1  one-cycle write strobe
read  out  1  one-cycle read strobe
write_data  out  32  write data to the peripheral
write_byteenable  out  4  byte enables to the peripheral
read_data  in  32  combinational read data, valid while `read` is high
address_error  in  1  combinational flag: `address` decodes to nothing
write_error  in  1  combinational flag: `address` is read-only

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst_n` is asynchronous and active-low; it clears every register.
- Reset values:
  - AWREADY=WREADY=ARREADY=1.
  - BVALID=RVALID=0; BRESP=RRESP=2'b00; RDATA=0.
  - write=read=0; address=0; write_data=0; write_byteenable=0.
  - FSM=IDLE; rr flag=0 (reads preferred first).
- Slots: three one-entry holding registers (AW, W, AR), each with a full flag.
  - A channel's READY = !full; READY has no combinational path from VALID.
  - A handshake (VALID & READY) loads the slot and sets full.
  - AW and W are accepted independently and in either order, including the same cycle.
- FSM states: IDLE, W_ACCESS, W_RESP, R_ACCESS, R_RESP.
- IDLE: write pending = AW full & W full; read pending = AR full.
  - Only one pending -> go to its ACCESS state.
  - Both pending -> rr=0 picks read, rr=1 picks write. rr toggles to the other type after each grant.
- W_ACCESS (exactly 1 cycle):
  - address = AW slot; write_data and write_byteenable = W slot.
  - write = !(address_error | write_error | misaligned).
  - BRESP register <= SLVERR (2'b10) if any of those three conditions, else OKAY (2'b00).
  - AW and W slots clear. Next state W_RESP.
- W_RESP: BVALID=1, held with BRESP stable until BREADY; then go to IDLE.
- R_ACCESS (exactly 1 cycle):
  - address = AR slot; read = !(address_error | misaligned).
  - RDATA <= read_data if read, else 0.
  - RRESP <= SLVERR on error, else OKAY. AR slot clears. Next state R_RESP.
- R_RESP: RVALID=1, held with RDATA/RRESP stable until RREADY; then go to IDLE.
- Latency (no backpressure):
  - Write: later of the AW/W handshakes at cycle N -> write strobe at N+2 -> BVALID at N+3.
  - Read: AR handshake at N -> read strobe at N+2 -> RVALID at N+3.
- Throughput: each slot can refill while the FSM is in a RESP state, so one new request per channel is accepted during the response.
- Address hold: `address` holds its last driven value outside the ACCESS states. write_data and write_byteenable are registered.
- Reset mid-transaction: all pending and in-flight transactions are dropped. No strobe and no response is produced for them after reset.

Decomposition:
- Shared package armleocpu_defines holds:
  - AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10.
  - FSM state encodings.
- Sub-module armleocpu_regslot (parameter WIDTH; ports in_valid/in_ready/in_data/clear/full/data) is instantiated three times, once each for AW, W and AR.

Test Plan:
- Write path: AW=0x4000 and W=0x12345678, WSTRB=0xF in the same cycle -> exactly one write strobe at +2 with address=0x4000 and data=0x12345678; BVALID at +3 with BRESP=00.
- Read path: AR=0xBFF8 with read_data driven to 0xCAFEBABE -> RVALID at +3, RDATA=0xCAFEBABE, RRESP=00.
- Channel order: W handshake 3 cycles before AW (AW=0x0, W=1) -> no strobe until AW is accepted; then a strobe with WSTRB carried through unchanged.
- Errors:
  - Write to 0xBFF8 with write_error=1 -> write stays 0, BRESP=10.
  - Read of 0x7000 with address_error=1 -> RDATA=0, RRESP=10.
  - Read of 0x2 -> RRESP=10 and no read strobe.
- Contention: AR and AW+W arrive together while BREADY/RREADY=0 for 5 cycles -> read is served first, BVALID/RVALID and data stay stable through the stall, then the write is served.
- Reset during W_RESP -> BVALID drops immediately; all READYs return to 1; no further strobes.
